// File: rtl/hilo_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_pkg
// Description : Shared word width and op / move-from encodings for hilo_muldiv.
// Revision    : 1.0 - initial release
// ============================================================================
package hilo_muldiv_pkg;

    localparam int c_WORD_W = 32;

    localparam logic [1:0] c_MULOP_MULT  = 2'b00;
    localparam logic [1:0] c_MULOP_MULTU = 2'b01;
    localparam logic [1:0] c_MULOP_DIV   = 2'b10;
    localparam logic [1:0] c_MULOP_DIVU  = 2'b11;

    localparam logic [1:0] c_MF_NONE = 2'b00;
    localparam logic [1:0] c_MF_HI   = 2'b01;
    localparam logic [1:0] c_MF_LO   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_if
// Description : EX-stage operand/control bundle and HI/LO results.
// Revision    : 1.0 - initial release
// ============================================================================
interface hilo_muldiv_if;
    import hilo_muldiv_pkg::*;

    logic                start;
    logic [1:0]          mul_op;
    logic                mt_en;
    logic                mt_hi;
    logic [1:0]          mf_sel;
    logic [c_WORD_W-1:0] src_a;
    logic [c_WORD_W-1:0] src_b;
    logic                busy;
    logic                stall;
    logic [c_WORD_W-1:0] mf_data;
    logic [c_WORD_W-1:0] hi;
    logic [c_WORD_W-1:0] lo;

    modport master (
        output start, mul_op, mt_en, mt_hi, mf_sel, src_a, src_b,
        input  busy, stall, mf_data, hi, lo
    );

    modport slave (
        input  start, mul_op, mt_en, mt_hi, mf_sel, src_a, src_b,
        output busy, stall, mf_data, hi, lo
    );

endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_core.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_core
// Description : Combinational 64-bit {hi,lo} result for mult/multu/div/divu.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_core
    import hilo_muldiv_pkg::*;
(
    input  wire logic [1:0]            i_op,
    input  wire logic [c_WORD_W-1:0]   i_a,
    input  wire logic [c_WORD_W-1:0]   i_b,
    output logic      [2*c_WORD_W-1:0] o_result,
    output logic                       o_we
);

    logic signed [2*c_WORD_W-1:0] w_a_ext;
    logic signed [2*c_WORD_W-1:0] w_b_ext;
    logic signed [2*c_WORD_W-1:0] w_prod_s;
    logic        [2*c_WORD_W-1:0] w_prod_u;
    logic                         w_div_zero;
    logic                         w_div_ovf;
    logic        [c_WORD_W-1:0]   w_divisor;
    logic signed [c_WORD_W-1:0]   w_quo_s;
    logic signed [c_WORD_W-1:0]   w_rem_s;
    logic        [c_WORD_W-1:0]   w_quo_u;
    logic        [c_WORD_W-1:0]   w_rem_u;

    assign w_a_ext  = {{c_WORD_W{i_a[c_WORD_W-1]}}, i_a};
    assign w_b_ext  = {{c_WORD_W{i_b[c_WORD_W-1]}}, i_b};
    assign w_prod_s = w_a_ext * w_b_ext;
    assign w_prod_u = {{c_WORD_W{1'b0}}, i_a} * {{c_WORD_W{1'b0}}, i_b};

    assign w_div_zero = (i_b == '0);
    assign w_div_ovf  = (i_op == c_MULOP_DIV) && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    // Dividing by 1 instead of -1 yields exactly the wrapped result (q=a, r=0)
    // and keeps the divider well-defined; a zero divisor is never committed.
    assign w_divisor = (w_div_zero || w_div_ovf) ? 32'd1 : i_b;
    assign w_quo_s   = $signed(i_a) / $signed(w_divisor);
    assign w_rem_s   = $signed(i_a) % $signed(w_divisor);
    assign w_quo_u   = i_a / w_divisor;
    assign w_rem_u   = i_a % w_divisor;

    always_comb begin
        o_result = '0;
        case (i_op)
            c_MULOP_MULT:  o_result = w_prod_s;
            c_MULOP_MULTU: o_result = w_prod_u;
            c_MULOP_DIV:   o_result = {w_rem_s, w_quo_s};
            c_MULOP_DIVU:  o_result = {w_rem_u, w_quo_u};
            default:       o_result = '0;
        endcase
    end

    assign o_we = !(i_op[1] && w_div_zero);

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv
// Description : Multi-cycle mul/div unit with HI/LO registers and stall request.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W      = 4
) (
    input  wire logic    clk,
    input  wire logic    reset,
    hilo_muldiv_if.slave bus
);

    localparam logic [0:0]       c_ST_IDLE = 1'b0;
    localparam logic [0:0]       c_ST_BUSY = 1'b1;
    localparam logic [CNT_W-1:0] c_MUL_CNT = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] c_DIV_CNT = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [0:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [c_WORD_W-1:0]   r_pend_hi;
    logic [c_WORD_W-1:0]   r_pend_lo;
    logic                  r_pend_we;
    logic [c_WORD_W-1:0]   r_hi;
    logic [c_WORD_W-1:0]   r_lo;

    logic [2*c_WORD_W-1:0] w_result;
    logic                  w_result_we;
    logic                  w_busy;
    logic                  w_mf_read;
    logic [c_WORD_W-1:0]   w_mf_data;

    hilo_muldiv_core u_core (
        .i_op     (bus.mul_op),
        .i_a      (bus.src_a),
        .i_b      (bus.src_b),
        .o_result (w_result),
        .o_we     (w_result_we)
    );

    // Starting takes priority over mthi/mtlo in IDLE; in BUSY both are ignored
    // because stall holds them upstream until the unit drains.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_we <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_pend_hi <= w_result[2*c_WORD_W-1:c_WORD_W];
                        r_pend_lo <= w_result[c_WORD_W-1:0];
                        r_pend_we <= w_result_we;
                        r_cnt     <= bus.mul_op[1] ? c_DIV_CNT : c_MUL_CNT;
                        r_state   <= c_ST_BUSY;
                    end else if (bus.mt_en) begin
                        if (bus.mt_hi) begin
                            r_hi <= bus.src_a;
                        end else begin
                            r_lo <= bus.src_a;
                        end
                    end
                end
                c_ST_BUSY: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        if (r_pend_we) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign w_busy    = (r_state == c_ST_BUSY);
    assign w_mf_read = (bus.mf_sel == c_MF_HI) || (bus.mf_sel == c_MF_LO);

    always_comb begin
        w_mf_data = '0;
        case (bus.mf_sel)
            c_MF_HI: w_mf_data = r_hi;
            c_MF_LO: w_mf_data = r_lo;
            default: w_mf_data = '0;
        endcase
    end

    assign bus.busy    = w_busy;
    assign bus.stall   = (w_busy || bus.start) && (bus.start || bus.mt_en || w_mf_read);
    assign bus.mf_data = w_mf_data;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;

endmodule
`default_nettype wire
